// File: rtl/billiard_pkg.sv
// Shared constants for the billiard table renderer: transparency code,
// pocket count limit, default pocket placement and the blink-phase helper.
package billiard_pkg;

    localparam int         MAX_HOLES            = 8;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef logic [MAX_HOLES-1:0][10:0] coord_tab_t;

    // Entry i is pocket i (concatenation lists index 7 down to 0).
    // Pockets 0..5: TL, TC, TR, BL, BC, BR on a 640x480 table; 6..7 are spare.
    localparam coord_tab_t DEFAULT_HOLE_X = {11'd0, 11'd0, 11'd608, 11'd304,
                                             11'd0, 11'd608, 11'd304, 11'd0};
    localparam coord_tab_t DEFAULT_HOLE_Y = {11'd0, 11'd0, 11'd448, 11'd448,
                                             11'd448, 11'd0, 11'd0, 11'd0};

    function automatic logic flash_phase(input logic [7:0] t, input int blink_bit);
        return (t != 8'd0) && t[blink_bit];
    endfunction

endpackage

// File: rtl/pocket_array_draw_if.sv
// Pixel/frame inputs and drawing outputs of the pocket renderer.
interface pocket_array_draw_if #(
    parameter int N_HOLES = 6
);
    logic                      startOfFrame;
    logic signed [10:0]        pixelX;
    logic signed [10:0]        pixelY;
    logic [N_HOLES-1:0]        pocketHit;
    logic                      drawingRequestHole;
    logic [7:0]                RGBoutHole;
    logic [2:0]                holeIndex;

    modport master (
        output startOfFrame, pixelX, pixelY, pocketHit,
        input  drawingRequestHole, RGBoutHole, holeIndex
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, pocketHit,
        output drawingRequestHole, RGBoutHole, holeIndex
    );
endinterface

// File: rtl/pocket_flash_timer.sv
// Per-pocket flash countdown: a hit reloads, each frame start counts down to 0.
module pocket_flash_timer #(
    parameter int FLASH_FRAMES = 32
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       hit,
    output logic [7:0] timer
);

    logic [7:0] timer_d, timer_q;

    // A hit outranks the frame tick, so a same-cycle hit never loses a frame.
    always_comb begin
        timer_d = timer_q;
        if (hit)
            timer_d = 8'(FLASH_FRAMES);
        else if (startOfFrame && (timer_q != 8'd0))
            timer_d = timer_q - 8'd1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) timer_q <= 8'd0;
        else         timer_q <= timer_d;
    end

    assign timer = timer_q;

endmodule

// File: rtl/pocket_array_draw.sv
// Draws N_HOLES circular pockets with optional blink highlight; 2-cycle pipe:
// stage 1 = offsets + box test, stage 2 = circle test, priority, colour.
module pocket_array_draw
    import billiard_pkg::*;
#(
    parameter int                       N_HOLES      = 6,
    parameter int                       RADIUS       = 16,
    parameter logic [N_HOLES-1:0][10:0] HOLE_X       = DEFAULT_HOLE_X[N_HOLES-1:0],
    parameter logic [N_HOLES-1:0][10:0] HOLE_Y       = DEFAULT_HOLE_Y[N_HOLES-1:0],
    parameter logic [7:0]               HOLE_COLOR   = 8'h00,
    parameter logic [7:0]               FLASH_COLOR  = 8'hFC,
    parameter int                       FLASH_FRAMES = 32,
    parameter int                       BLINK_BIT    = 2
) (
    input logic                 clk,
    input logic                 resetN,
    pocket_array_draw_if.slave  bus
);

    localparam int                 STAGES = 2;
    localparam logic signed [12:0] BOX    = 13'(2 * RADIUS);
    localparam logic signed [31:0] R2     = 32'(4 * RADIUS * RADIUS);

    // Stage 1 state
    logic [N_HOLES-1:0][12:0] dx_d, dx_q, dy_d, dy_q;
    logic [N_HOLES-1:0]       box_d, box_q;
    logic [STAGES:1]          vld_pipe_d, vld_pipe_q;

    // Stage 2 state
    logic [7:0] rgb_d, rgb_q;
    logic [2:0] idx_d, idx_q;

    logic [N_HOLES-1:0]      in_circ;
    logic [N_HOLES-1:0][7:0] col;
    logic [N_HOLES-1:0][7:0] timer;

    // Offsets are 13-bit signed: pixel is -1024..1023, corner 0..2047.
    always_comb begin
        dx_d  = '0;
        dy_d  = '0;
        box_d = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            dx_d[i]  = {{2{bus.pixelX[10]}}, bus.pixelX} - {2'b00, HOLE_X[i]};
            dy_d[i]  = {{2{bus.pixelY[10]}}, bus.pixelY} - {2'b00, HOLE_Y[i]};
            box_d[i] = ($signed(dx_d[i]) >= 0) && ($signed(dx_d[i]) < BOX) &&
                       ($signed(dy_d[i]) >= 0) && ($signed(dy_d[i]) < BOX);
        end
    end

    assign vld_pipe_d = {vld_pipe_q[STAGES-1:1], 1'b1};

    genvar g;
    generate
        for (g = 0; g < N_HOLES; g++) begin : g_pocket
            logic signed [31:0] ox, oy, sq_sum;

            // Doubled offsets from the box centre keep the radius test integral.
            assign ox      = 2 * $signed(dx_q[g]) - (2 * RADIUS - 1);
            assign oy      = 2 * $signed(dy_q[g]) - (2 * RADIUS - 1);
            assign sq_sum  = ox * ox + oy * oy;
            assign in_circ[g] = box_q[g] && (sq_sum <= R2);

            pocket_flash_timer #(
                .FLASH_FRAMES (FLASH_FRAMES)
            ) u_timer (
                .clk          (clk),
                .resetN       (resetN),
                .startOfFrame (bus.startOfFrame),
                .hit          (bus.pocketHit[g]),
                .timer        (timer[g])
            );

            assign col[g] = flash_phase(timer[g], BLINK_BIT) ? FLASH_COLOR : HOLE_COLOR;
        end
    endgenerate

    // Descending scan so the lowest-index pocket is written last and wins.
    always_comb begin
        rgb_d = TRANSPARENT_ENCODING;
        idx_d = 3'd0;
        if (vld_pipe_q[1]) begin
            for (int i = N_HOLES - 1; i >= 0; i--) begin
                if (in_circ[i]) begin
                    rgb_d = col[i];
                    idx_d = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dx_q       <= '0;
            dy_q       <= '0;
            box_q      <= '0;
            vld_pipe_q <= '0;
            rgb_q      <= TRANSPARENT_ENCODING;
            idx_q      <= 3'd0;
        end else begin
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            box_q      <= box_d;
            vld_pipe_q <= vld_pipe_d;
            rgb_q      <= rgb_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.RGBoutHole         = rgb_q;
    assign bus.holeIndex          = idx_q;
    assign bus.drawingRequestHole = vld_pipe_q[STAGES] && (rgb_q != TRANSPARENT_ENCODING);

endmodule

// File: doc/pocket_array_draw.md
POCKET_ARRAY_DRAW -- requirements
Module: pocket_array_draw

Interface
REQ-001 Parameter N_HOLES, default 6: number of pockets drawn; legal range 1..8.
REQ-002 Parameter RADIUS, default 16: pocket radius in pixels; each pocket's bounding box is 2*RADIUS square.
REQ-003 Parameter HOLE_X / HOLE_Y, array of N_HOLES 11-bit values, default standard table corners and side centres: top-left corner of each pocket's bounding box.
REQ-004 Parameter HOLE_COLOR, default 8'h00: normal pocket colour.
REQ-005 Parameter FLASH_COLOR, default 8'hFC: highlight colour.
REQ-006 Parameter FLASH_FRAMES, default 32: flash duration in frames; range 1..255.
REQ-007 Parameter BLINK_BIT, default 2: timer bit that selects the blink phase.
REQ-008 clk  in  1  system clock; single clock domain.
REQ-009 resetN  in  1  asynchronous, active-low reset.
REQ-010 startOfFrame  in  1  one-cycle pulse, once per video frame.
REQ-011 pixelX  in  11 signed  current pixel column.
REQ-012 pixelY  in  11 signed  current pixel row.
REQ-013 pocketHit  in  N_HOLES  one-cycle pulse per pocket when a ball is sunk.
REQ-014 drawingRequestHole  out  1  high when RGBoutHole is not transparent.
REQ-015 RGBoutHole  out  8  pixel colour; 8'hFF is transparent.
REQ-016 holeIndex  out  3  index of the pocket being drawn; 0 when none.

Function
REQ-017 Circle test: inside pocket i when (2*(pixelX-HOLE_X[i])-(2*RADIUS-1))^2 + (2*(pixelY-HOLE_Y[i])-(2*RADIUS-1))^2 <= (2*RADIUS)^2; all terms are signed, at least 24 bits wide, and exact with no overflow.
REQ-018 Pixels outside the bounding box [HOLE_X, HOLE_X+2*RADIUS) x [HOLE_Y, HOLE_Y+2*RADIUS) are never inside; negative pixelX and pixelY are handled as signed values.
REQ-019 Pipeline: stage 1 registers the per-pocket offsets and box-hit flags; stage 2 registers the square-sum compare, the priority select and the colour. Latency is exactly 2 clk from pixel input to RGBoutHole.
REQ-020 Overlapping pockets: the lowest index wins.
REQ-021 Each pocket has an 8-bit flash timer. A pocketHit[i] pulse loads FLASH_FRAMES. When startOfFrame is high and the timer is nonzero, the timer decrements by 1. It saturates at 0.
REQ-022 When pocketHit[i] and startOfFrame occur in the same cycle, the load wins; no decrement happens in that cycle.
REQ-023 A pocketHit[i] pulse while pocket i is already flashing restarts the timer at FLASH_FRAMES.
REQ-024 Pocket colour: if the timer is nonzero and timer[BLINK_BIT] is 1, the colour is FLASH_COLOR; otherwise it is HOLE_COLOR.
REQ-025 Flash timers are per pocket and independent; any number of pockets may flash at once.
REQ-026 The colour uses the timer value sampled in stage 2, so a timer change mid-frame takes effect 2 clk later.
REQ-027 No pocket hit: RGBoutHole=8'hFF and holeIndex=0.
REQ-028 drawingRequestHole is combinational from the registered RGBoutHole and equals (RGBoutHole != 8'hFF).

Reset
REQ-029 While resetN is low: RGBoutHole=8'hFF, holeIndex=0, drawingRequestHole=0, all pipeline registers are cleared, and all flash timers are 0.
REQ-030 Reset asserted mid-flash aborts the flash immediately. After release, the first valid output appears on the 2nd rising edge.

Structure
REQ-031 Package billiard_pkg holds TRANSPARENT_ENCODING=8'hFF, the default pocket position tables, and the N_HOLES limit.
REQ-032 Sub-module pocket_flash_timer, one instance per pocket via generate, implements REQ-021..REQ-023 with ports clk, resetN, startOfFrame, hit, timer[7:0].

Verification
REQ-033 Pocket 0 at (0,0), RADIUS=16, pixel (16,16) -> after 2 clk RGBoutHole=8'h00, holeIndex=0, drawingRequestHole=1. Pixels (0,0) and (31,0) -> 8'hFF.
REQ-034 Pixels (-1,5) and (32,16) -> 8'hFF. Pixel (31,16) -> 8'h00. Back-to-back pixels stream with one output per clk.
REQ-035 pocketHit[2] pulse, then 40 startOfFrame pulses -> pocket 2 colour is 8'hFC on frames where timer[2]=1 and 8'h00 otherwise; after frame 32 it stays 8'h00.
REQ-036 pocketHit[1] and startOfFrame in the same cycle -> timer=FLASH_FRAMES, not FLASH_FRAMES-1. A re-hit at timer=5 -> timer returns to 32.
REQ-037 Two pockets with overlapping boxes -> the lower index is reported on holeIndex and its colour is used.
REQ-038 resetN pulsed low mid-flash -> outputs go to 8'hFF/0 asynchronously, the timer is 0, and no flash appears after release.
